pingpong_dir_ctrl: RTL

PINGPONG_DIR_CTRL -- requirements
Module: pingpong_dir_ctrl

---
 rtl/pingpong_dir_ctrl_pkg.sv | 18 +
 rtl/pingpong_dir_ctrl_rev_req_conditioner.sv | 68 ++++++
 rtl/pingpong_dir_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/pingpong_dir_ctrl_pkg.sv
// Shared types and default parameter values for the ping-pong direction controller.
package pingpong_dir_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } state_e;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_HI_LIM  = 12;
    localparam int DEF_LO_LIM  = 3;
    localparam int DEF_HOLDOFF = 2;
    localparam int DEF_DB_CYC  = 4;

    localparam logic [7:0] TURN_CNT_MAX = 8'hFF;

endpackage

// File: rtl/pingpong_dir_ctrl_rev_req_conditioner.sv
// Turns the manual reverse request level into a one-cycle registered accept pulse.
// DIR_DEBOUNCE_EN defined  : 2-flop synchronizer + DB_CYC-cycle stable-high debounce,
//                            one accept per qualified high period.
// DIR_DEBOUNCE_EN undefined: input treated as synchronous, accept on its rising edge.
module rev_req_conditioner
    import pingpong_dir_ctrl_pkg::*;
#(
    parameter int DB_CYC = DEF_DB_CYC
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_rev_req,
    output logic o_accept
);

    // No module of this name exists: a zero debounce length stops elaboration.
    if (DB_CYC < 1) begin : g_bad_db_cyc
        illegal_db_cyc_parameter u_err ();
    end

    logic r_accept;

`ifdef DIR_DEBOUNCE_EN
    localparam logic [7:0] DB_CYC_C = 8'(DB_CYC);

    logic       r_sync1;
    logic       r_sync2;
    logic [7:0] r_db_cnt;

    // Synchronize, then count consecutive high samples; fire once when the count completes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_db_cnt <= 8'd0;
            r_accept <= 1'b0;
        end else begin
            r_sync1  <= i_rev_req;
            r_sync2  <= r_sync1;
            r_accept <= 1'b0;
            if (!r_sync2) begin
                r_db_cnt <= 8'd0;
            end else if (r_db_cnt < DB_CYC_C) begin
                r_db_cnt <= r_db_cnt + 8'd1;
                if (r_db_cnt == DB_CYC_C - 8'd1) begin
                    r_accept <= 1'b1;
                end
            end
        end
    end
`else
    logic r_prev;

    // Rising-edge detect against the previous sample.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prev   <= 1'b0;
            r_accept <= 1'b0;
        end else begin
            r_prev   <= i_rev_req;
            r_accept <= i_rev_req & ~r_prev;
        end
    end
`endif

    assign o_accept = r_accept;

endmodule

// File: rtl/pingpong_dir_ctrl.sv
// Ping-pong direction controller: steers an up/down counter between LO_LIM and HI_LIM,
// with a post-turn holdoff on limit checks and a manual reverse request.
// Optional macro DIR_DEBOUNCE_EN selects the debounced reverse-request path.
// Handshake-free block: o_turn is a single-cycle registered strobe, o_dir a registered level.
module pingpong_dir_ctrl
    import pingpong_dir_ctrl_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int HI_LIM  = DEF_HI_LIM,
    parameter int LO_LIM  = DEF_LO_LIM,
    parameter int HOLDOFF = DEF_HOLDOFF,
    parameter int DB_CYC  = DEF_DB_CYC
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_rev_req,
    output logic             o_dir,
    output logic             o_turn,
    output logic [7:0]       o_turn_cnt,
    output logic             o_sat,
    output state_e           o_state
);

    localparam logic [WIDTH-1:0] HI_C      = WIDTH'(HI_LIM);
    localparam logic [WIDTH-1:0] LO_C      = WIDTH'(LO_LIM);
    localparam logic [7:0]       HOLDOFF_C = 8'(HOLDOFF);

    // No module of this name exists: inverted limits stop elaboration.
    if (LO_LIM >= HI_LIM) begin : g_bad_limits
        illegal_limit_parameters u_err ();
    end

    logic [WIDTH-1:0] r_q;
    state_e           r_state;
    logic             r_dir;
    logic             r_turn;
    logic [7:0]       r_turn_cnt;
    logic [7:0]       r_holdoff;

    state_e           w_state_next;
    logic             w_dir_next;
    logic             w_turn_next;
    logic             w_accept;
    logic             w_hold_exp;
    logic             w_hi_hit;
    logic             w_lo_hit;

    rev_req_conditioner #(
        .DB_CYC (DB_CYC)
    ) u_cond (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_rev_req (i_rev_req),
        .o_accept  (w_accept)
    );

    assign w_hold_exp = (r_holdoff == 8'd0);
    assign w_hi_hit   = (r_q >= HI_C) && w_hold_exp;
    assign w_lo_hit   = (r_q <= LO_C) && w_hold_exp;

    // Next state: en dominates; limit and accept are OR-ed so a coincidence yields one turn;
    // a turn is never issued right after another.
    always_comb begin
        w_state_next = r_state;
        w_dir_next   = r_dir;
        w_turn_next  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_en) begin
                    w_state_next = r_dir ? ST_UP : ST_DOWN;
                end
            end
            ST_UP: begin
                if (!i_en) begin
                    w_state_next = ST_IDLE;
                end else if (!r_turn && (w_hi_hit || w_accept)) begin
                    w_state_next = ST_DOWN;
                    w_dir_next   = 1'b0;
                    w_turn_next  = 1'b1;
                end
            end
            ST_DOWN: begin
                if (!i_en) begin
                    w_state_next = ST_IDLE;
                end else if (!r_turn && (w_lo_hit || w_accept)) begin
                    w_state_next = ST_UP;
                    w_dir_next   = 1'b1;
                    w_turn_next  = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register with the registered q sample and direction/turn outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q     <= '0;
            r_state <= ST_IDLE;
            r_dir   <= 1'b1;
            r_turn  <= 1'b0;
        end else begin
            r_q     <= i_q;
            r_state <= w_state_next;
            r_dir   <= w_dir_next;
            r_turn  <= w_turn_next;
        end
    end

    // Holdoff reloads on every turn and drains to zero; turn count saturates at 255.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_holdoff  <= 8'd0;
            r_turn_cnt <= 8'd0;
        end else if (w_turn_next) begin
            r_holdoff <= HOLDOFF_C;
            if (r_turn_cnt != TURN_CNT_MAX) begin
                r_turn_cnt <= r_turn_cnt + 8'd1;
            end
        end else if (r_holdoff != 8'd0) begin
            r_holdoff <= r_holdoff - 8'd1;
        end
    end

    assign o_dir      = r_dir;
    assign o_turn     = r_turn;
    assign o_turn_cnt = r_turn_cnt;
    assign o_sat      = (r_turn_cnt == TURN_CNT_MAX);
    assign o_state    = r_state;

endmodule
